serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder.
- Latches two WIDTH-bit operands and a carry-in on a start pulse.
- Presents one bit pair per clock, LSB first, to an internal one-bit full-adder cell (sum = a^b^c, carry = a&b | c&(a^b)), with the carry held in a flip-flop between cycles.
- Sits upstream of result-consuming logic and replaces wide combinational adders where area matters more than latency.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising edge of clk.
- a  input  WIDTH  operand A; sampled only when start is accepted.
- b  input  WIDTH  operand B; sampled only when start is accepted.
- cin  input  1  carry-in; sampled only when start is accepted.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, internal shift registers and carry flop=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: load A/B shift registers from a/b, carry flop from cin, counter=0, sum-accumulate register=0; go to SHIFT; busy=1 from cycle k+1.
  - start=0: stay in IDLE.
- SHIFT: each edge does the following.
  - Compute one bit from A[0], B[0] and the carry flop.
  - Shift the sum bit into the accumulate register from the MSB side.
  - Shift A and B right by one.
  - Update the carry flop.
  - Increment the counter.
- End of SHIFT: at edge k+WIDTH (counter reaches WIDTH-1 on the processing edge):
  - sum <= final accumulate value.
  - cout <= final carry.
  - busy <= 0, done <= 1; go to DONE.
- DONE: lasts one cycle; done returns to 0 on the next edge. Go to IDLE, or accept a new start exactly as IDLE does.
- Latency: start sampled at edge k, so sum/cout/done update at edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Outputs sum/cout change only at the completion edge and hold the last result until the next completion. They never show partial values.
- start while busy=1 is ignored: no restart, no queueing, operands not resampled.
- a/b/cin may change freely after the accepting edge without effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned, no saturation.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No done pulse. The previous sum/cout are cleared to 0.
- Reset release: first start is accepted on the first rising edge with rst_n=1.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is registered alongside sum/cout at the completion edge.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow. It holds like sum.
- Undefined: no ovf port and no associated logic. Behaviour is otherwise identical.

Test Plan (WIDTH=8):
- Basic add: a=0x3C, b=0x0F, cin=0, start pulse at edge k -> busy=1 over k+1..k+8; at edge k+8 sum=0x4B, cout=0, done=1 for one cycle.
- Carry ripple/wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start ignored while busy:
  - Start with a=0x10, b=0x20.
  - Pulse start with a=0x01, b=0x01 at k+3.
  - Required: result at k+8 is sum=0x30; no second done.
  - The previous result (0xFF from the prior test) stays held through k+7.
- Back-to-back via DONE: assert start in the done cycle with a=0x05, b=0x03 -> accepted; sum=0x08 exactly 8 edges later.
- Reset mid-op: deassert rst_n asynchronously at k+4 -> busy=0, done=0, sum=0x00, cout=0 immediately. After release, a new start with a=0x02, b=0x02 gives sum=0x04 normally.
- With SERIAL_ADDER_OVERFLOW_EN:
  - a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0.
  - a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1.
  - a=0x10, b=0x10 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder.
// A start pulse latches a, b and cin. One bit pair per clock (LSB first)
// then goes through a one-bit full-adder cell, with the carry held in a
// flop between cycles. sum/cout (and ovf when enabled) are registered at
// the completion edge and hold until the next completion.
//
// Build option:
//   SERIAL_ADDER_OVERFLOW_EN - adds output ovf, the two's-complement
//                              signed overflow of the last result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last value
// SHIFT | one bit per edge; counter counts 0..WIDTH-1
// DONE  | single-cycle done pulse; a new start is accepted here as well

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    // One-bit full-adder cell.
    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
    end
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             load;
    logic             step;
    logic             finish;
    logic             last_bit;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] acc_next;

    serial_adder_fa u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (carry_q),
        .s  (fa_sum),
        .co (fa_carry)
    );

    // Sum bits enter from the MSB side so that after WIDTH steps the
    // first (LSB) bit has arrived at position 0.
    always_comb begin
        acc_next = {fa_sum, acc_q[WIDTH-1:1]};
        last_bit = (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here: no restart,
                // no queueing.
                step = 1'b1;
                if (last_bit) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flop, bit counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            acc_q   <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            acc_q   <= acc_next;
            carry_q <= fa_carry;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Result registers; they change only at the completion edge, so
    // partial sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (finish) begin
            sum_q  <= acc_next;
            cout_q <= fa_carry;
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q;

    // On the final step carry_q is the carry into the MSB and fa_carry is
    // the carry out of it; their XOR is the signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (finish) begin
            ovf_q <= carry_q ^ fa_carry;
        end
    end

    assign ovf = ovf_q;
`endif

    // busy and done are decoded straight from the state register, so they
    // are glitch-free and reset to 0 together with the state.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed test for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts an operation from the current cycle (start sampled at the
    // next edge k), checks busy/done/held result over k+1..k+8 and the
    // result at edge k+8. Returns in the done cycle.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_cin,
                          input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] prev_sum, input logic prev_cout,
                          input string tag);
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~op_a;
        b     = ~op_b;
        cin   = ~op_cin;
        for (int i = 0; i < 8; i++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_low"}, 32'(done), 32'd0);
            chk({tag, " sum_hold"}, 32'(sum), 32'(prev_sum));
            chk({tag, " cout_hold"}, 32'(cout), 32'(prev_cout));
            tick();
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_low"}, 32'(busy), 32'd0);
        chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, " cout"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #23;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("rst ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add.
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b0, "basic");
        tick();
        chk("basic done_drop", 32'(done), 32'd0);
        chk("basic sum_keep", 32'(sum), 32'h4B);
        chk("basic idle_busy", 32'(busy), 32'd0);

        // Carry ripple and full wrap.
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h4B, 1'b0, "wrap1");
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, "wrap2");
        tick();

        // start while busy is ignored.
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                a     = 8'h01;
                b     = 8'h01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("ign busy", 32'(busy), 32'd1);
            chk("ign done_low", 32'(done), 32'd0);
            chk("ign sum_hold", 32'(sum), 32'hFF);
            tick();
        end
        start = 1'b0;
        chk("ign done", 32'(done), 32'd1);
        chk("ign sum", 32'(sum), 32'h30);
        chk("ign cout", 32'(cout), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ign no_second_done", 32'(done), 32'd0);
            chk("ign no_restart", 32'(busy), 32'd0);
            chk("ign sum_keep", 32'(sum), 32'h30);
        end

        // Back-to-back: new start taken in the done cycle.
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 8'h30, 1'b0, "b2b_first");
        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 8'h33, 1'b0, "b2b_second");
        tick();
        chk("b2b done_drop", 32'(done), 32'd0);

        // Asynchronous reset in the middle of an operation.
        a     = 8'h40;
        b     = 8'h40;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid done", 32'(done), 32'd0);
        chk("mid sum", 32'(sum), 32'h00);
        chk("mid cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 8'h00, 1'b0, "post_rst");
        tick();

`ifdef SERIAL_ADDER_OVERFLOW_EN
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8'h04, 1'b0, "ovf_pos");
        chk("ovf_pos ovf", 32'(ovf), 32'd1);
        tick();
        chk("ovf_pos ovf_hold", 32'(ovf), 32'd1);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, "ovf_neg");
        chk("ovf_neg ovf", 32'(ovf), 32'd1);
        tick();
        run_op(8'h10, 8'h10, 1'b0, 8'h20, 1'b0, 8'h00, 1'b1, "ovf_none");
        chk("ovf_none ovf", 32'(ovf), 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
